// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit: FSM encoding,
// queue entry layout and the saturating counter helper.
package branch_resolve_unit_pkg;

   localparam int          PC_W   = 32;
   localparam logic [31:0] PC_INC = 32'd4;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            taken;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (&value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute facing bus of the branch resolve unit. The master side is the
// pipeline (fetch + execute), the slave side is the resolve unit.
interface branch_resolve_unit_if;
   import branch_resolve_unit_pkg::*;

   logic            pred_valid;
   logic [PC_W-1:0] pred_pc;
   logic            pred_taken;
   logic            pred_ready;
   logic            res_valid;
   logic            res_taken;
   logic [PC_W-1:0] res_target;
   logic            update_enable;
   logic [PC_W-1:0] update_pc;
   logic            actual_taken;
   logic            flush;
   logic [PC_W-1:0] redirect_pc;
   logic            res_error;

   modport master (
      output pred_valid, pred_pc, pred_taken, res_valid, res_taken, res_target,
      input  pred_ready, update_enable, update_pc, actual_taken, flush,
             redirect_pc, res_error
   );

   modport slave (
      input  pred_valid, pred_pc, pred_taken, res_valid, res_taken, res_target,
      output pred_ready, update_enable, update_pc, actual_taken, flush,
             redirect_pc, res_error
   );

endinterface

// File: rtl/branch_resolve_unit_queue.sv
// In-order queue of predicted branches: wrapping pointers plus an explicit
// count, with a synchronous clear that wins over push and pop.
module branch_queue
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  entry_t              push_data,
   input  logic                pop,
   input  logic                clear,
   output entry_t              head,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_LOG2:0] count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   entry_t                mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign head    = mem[rd_ptr];

   // NOTE: storage is deliberately not reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the oldest predicted branch against execute's outcome, emits the
// predictor update, a one-cycle flush/redirect on mispredict, and perf counters.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter  int DEPTH_LOG2 = 2,
   localparam int DEPTH      = 1 << DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   branch_resolve_unit_if.slave  bus,
   output logic [DEPTH_LOG2:0]   occupancy,
   output logic [31:0]           branch_count,
   output logic [31:0]           mispredict_count
);

   state_t state;
   entry_t head;
   entry_t push_data;
   logic   full;
   logic   empty;
   logic   push_fire;
   logic   pop_fire;
   logic   empty_res;
   logic   mispredict;

   // Ready is gated by reset so fetch sees no acceptance while rst is held low.
   assign bus.pred_ready = rst && (state == ST_RUN) && !full;
   assign push_fire      = bus.pred_valid && bus.pred_ready;
   assign push_data      = '{pc: bus.pred_pc, taken: bus.pred_taken};

   assign pop_fire   = (state == ST_RUN) && bus.res_valid && !empty;
   assign empty_res  = (state == ST_RUN) && bus.res_valid && empty;
   assign mispredict = pop_fire && (head.taken != bus.res_taken);

   branch_queue #(.DEPTH_LOG2(DEPTH_LOG2)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push_fire),
      .push_data (push_data),
      .pop       (pop_fire),
      .clear     (mispredict),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (occupancy)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= ST_RUN;
         bus.update_enable <= 1'b0;
         bus.update_pc     <= '0;
         bus.actual_taken  <= 1'b0;
         bus.flush         <= 1'b0;
         bus.redirect_pc   <= '0;
         bus.res_error     <= 1'b0;
         branch_count      <= '0;
         mispredict_count  <= '0;
      end else begin
         state             <= mispredict ? ST_FLUSH : ST_RUN;
         bus.update_enable <= pop_fire;
         bus.flush         <= mispredict;
         bus.res_error     <= empty_res;
         if (pop_fire) begin
            bus.update_pc    <= head.pc;
            bus.actual_taken <= bus.res_taken;
            branch_count     <= sat_inc(branch_count);
         end
         if (mispredict) begin
            bus.redirect_pc  <= bus.res_taken ? bus.res_target : head.pc + PC_INC;
            mispredict_count <= sat_inc(mispredict_count);
         end
      end
   end

endmodule
